e_bloques_datos: RTL and testbench
==================================

E_BLOQUES_DATOS -- requirements
Module: e_bloques_datos

Interface
REQ-001 Parameter COD_I, default 4'd1, select code enabling the initialization counter.
REQ-002 Parameter COD_MS, default 4'd2, select code enabling the mode/setting counter.
REQ-003 Parameter COD_FECHA, default 4'd3, select code enabling the date counter.
REQ-004 Parameter COD_HORA, default 4'd4, select code enabling the time counter.
REQ-005 Parameter COD_CRONO, default 4'd5, select code enabling the chronometer counter.
REQ-006 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 Selec_Mux_DDw  input  4  data-block select code from the display/mux path.
REQ-010 enable_cont_I  output  1  enable for the initialization counter.
REQ-011 enable_cont_MS  output  1  enable for the mode/setting counter.
REQ-012 enable_cont_fecha  output  1  enable for the date counter.
REQ-013 enable_cont_hora  output  1  enable for the time counter.
REQ-014 enable_cont_crono  output  1  enable for the chronometer counter.

Function
REQ-015 The block SHALL register Selec_Mux_DDw on every rising clk edge; no combinational path from input to outputs.
REQ-016 On the edge that samples code COD_I, enable_cont_I SHALL be 1 from that edge on; likewise COD_MS->enable_cont_MS, COD_FECHA->enable_cont_fecha, COD_HORA->enable_cont_hora, COD_CRONO->enable_cont_crono.
REQ-017 Latency SHALL be exactly one clock: output reflects the input value present at the preceding rising edge.
REQ-018 The five enables SHALL be mutually exclusive (one-hot or all-zero) in every cycle, including immediately after a code change.
REQ-019 Code 4'd0 and every code not equal to a COD_* parameter (defaults: 0, 6-15) SHALL drive all five enables to 0.
REQ-020 An enable SHALL remain asserted for as long as its code is held, one cycle per held cycle, with no glitches between consecutive identical codes.
REQ-021 When the code changes directly from one valid code to another, the old enable SHALL drop and the new one rise on the same edge (no overlap, no gap cycle).
REQ-022 If two COD_* parameters are set equal, the lower-numbered output in REQ-010..014 order SHALL win and the other SHALL stay 0.
REQ-023 Select input SHALL be treated as unsigned 4-bit; wrap from 15 to 0 requires no special handling beyond REQ-019.
REQ-024 X/Z on Selec_Mux_DDw is not supported; no recovery behaviour required.

Reset
REQ-025 While reset=0, the registered select SHALL be 4'd0 and all five enables SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL clear all enables immediately (asynchronously), not at the next edge.
REQ-027 After reset deasserts, the first rising edge SHALL sample Selec_Mux_DDw normally per REQ-016/019.

Verification
REQ-028 reset=0, Selec_Mux_DDw=4'd3, clock running -> all enables 0 throughout reset.
REQ-029 Sweep Selec_Mux_DDw 0..15, holding each value 10 clocks -> only enable_cont_I during code 1, MS during 2, fecha during 3, hora during 4, crono during 5; all zero for 0 and 6-15; each transition one clock after the input change.
REQ-030 Step code 4->5 between two edges -> enable_cont_hora 1->0 and enable_cont_crono 0->1 on the same edge; assertion checks at most one enable high every cycle.
REQ-031 Code 5 held, reset pulsed low between edges -> enable_cont_crono falls at reset assertion, rises again on first edge after release.
REQ-032 Wrap 15->0->1 -> all zero at 15 and 0, enable_cont_I 1 one clock after code 1 applied.

Source files
------------

// File: rtl/e_bloques_datos.sv
// rtl/e_bloques_datos.sv - registered one-hot counter enables decoded from the data-block select code
// Decoding happens before the flops, so the enables come straight from registers with async clear.
module e_bloques_datos #(
  parameter logic [3:0] COD_I     = 4'd1,
  parameter logic [3:0] COD_MS    = 4'd2,
  parameter logic [3:0] COD_FECHA = 4'd3,
  parameter logic [3:0] COD_HORA  = 4'd4,
  parameter logic [3:0] COD_CRONO = 4'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Selec_Mux_DDw,
  output logic       enable_cont_I,
  output logic       enable_cont_MS,
  output logic       enable_cont_fecha,
  output logic       enable_cont_hora,
  output logic       enable_cont_crono
);

  // Bit order {I, MS, fecha, hora, crono}.
  logic [4:0] enable_d;
  logic [4:0] enable_q;

  // The priority chain keeps the outputs one-hot even when two codes are configured equal.
  always_comb begin
    enable_d = 5'b00000;
    if (Selec_Mux_DDw == COD_I) begin
      enable_d = 5'b10000;
    end else if (Selec_Mux_DDw == COD_MS) begin
      enable_d = 5'b01000;
    end else if (Selec_Mux_DDw == COD_FECHA) begin
      enable_d = 5'b00100;
    end else if (Selec_Mux_DDw == COD_HORA) begin
      enable_d = 5'b00010;
    end else if (Selec_Mux_DDw == COD_CRONO) begin
      enable_d = 5'b00001;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q <= 5'b00000;
    end else begin
      enable_q <= enable_d;
    end
  end

  assign enable_cont_I     = enable_q[4];
  assign enable_cont_MS    = enable_q[3];
  assign enable_cont_fecha = enable_q[2];
  assign enable_cont_hora  = enable_q[1];
  assign enable_cont_crono = enable_q[0];

endmodule

// File: tb/tb_e_bloques_datos.sv
// tb/tb_e_bloques_datos.sv - scoreboard bench for e_bloques_datos with default and overlapping code maps
module tb_e_bloques_datos;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sel = 4'd3;
  logic       a_i, a_ms, a_fe, a_ho, a_cr;
  logic       b_i, b_ms, b_fe, b_ho, b_cr;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_a_q[$];
  logic [4:0] exp_b_q[$];

  // Code maps in output order I, MS, fecha, hora, crono.
  localparam logic [19:0] MAP_A = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  localparam logic [19:0] MAP_B = {4'd1, 4'd1, 4'd3, 4'd3, 4'd9};

  always #5 clk = ~clk;

  e_bloques_datos dut_a (
    .clk(clk), .reset(reset), .Selec_Mux_DDw(sel),
    .enable_cont_I(a_i), .enable_cont_MS(a_ms), .enable_cont_fecha(a_fe),
    .enable_cont_hora(a_ho), .enable_cont_crono(a_cr)
  );

  e_bloques_datos #(
    .COD_I(4'd1), .COD_MS(4'd1), .COD_FECHA(4'd3), .COD_HORA(4'd3), .COD_CRONO(4'd9)
  ) dut_b (
    .clk(clk), .reset(reset), .Selec_Mux_DDw(sel),
    .enable_cont_I(b_i), .enable_cont_MS(b_ms), .enable_cont_fecha(b_fe),
    .enable_cont_hora(b_ho), .enable_cont_crono(b_cr)
  );

  // First matching output in list order wins; no match leaves everything low.
  function automatic logic [4:0] model(input logic [3:0] code, input logic [19:0] map);
    logic [4:0] r;
    r = 5'b0;
    for (int k = 0; k < 5; k++) begin
      if (r == 5'b0 && map[19 - 4*k -: 4] == code) r[4 - k] = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %b required %b at %0t", name, got, req, $time);
    end
  endtask

  task automatic apply(input logic [3:0] code);
    @(negedge clk);
    sel = code;
    exp_a_q.push_back(model(code, MAP_A));
    exp_b_q.push_back(model(code, MAP_B));
  endtask

  // Monitor: every cycle the enables are live outputs, so pop whenever an expectation is pending.
  always @(posedge clk) begin
    logic [4:0] ga, gb;
    #1;
    ga = {a_i, a_ms, a_fe, a_ho, a_cr};
    gb = {b_i, b_ms, b_fe, b_ho, b_cr};
    check("onehot_a", {4'b0, ($countones(ga) > 1)}, 5'b0);
    check("onehot_b", {4'b0, ($countones(gb) > 1)}, 5'b0);
    if (exp_a_q.size() > 0) check("enables_a", ga, exp_a_q.pop_front());
    if (exp_b_q.size() > 0) check("enables_b", gb, exp_b_q.pop_front());
  end

  initial begin
    int hold;
    logic [3:0] c;

    // Held in reset with a valid code and a running clock.
    repeat (5) begin
      @(posedge clk);
      #2;
      check("in_reset_a", {a_i, a_ms, a_fe, a_ho, a_cr}, 5'b0);
      check("in_reset_b", {b_i, b_ms, b_fe, b_ho, b_cr}, 5'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    sel = 4'd3;
    exp_a_q.push_back(model(4'd3, MAP_A));
    exp_b_q.push_back(model(4'd3, MAP_B));

    for (int v = 0; v < 16; v++) begin
      repeat (10) apply(v[3:0]);
    end

    apply(4'd4); apply(4'd4); apply(4'd5); apply(4'd5);
    apply(4'd15); apply(4'd15); apply(4'd0); apply(4'd1); apply(4'd1);

    // Async reset mid-operation with code 5 held, released between edges.
    repeat (3) apply(4'd5);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_clear", {a_i, a_ms, a_fe, a_ho, a_cr}, 5'b0);
    @(posedge clk);
    #2;
    check("reset_held", {a_i, a_ms, a_fe, a_ho, a_cr}, 5'b0);
    @(negedge clk);
    reset = 1'b1;
    sel = 4'd5;
    exp_a_q.push_back(model(4'd5, MAP_A));
    exp_b_q.push_back(model(4'd5, MAP_B));
    #1;
    check("pre_edge_after_release", {a_i, a_ms, a_fe, a_ho, a_cr}, 5'b0);
    apply(4'd5);

    repeat (150) begin
      c = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 4);
      repeat (hold) apply(c);
    end

    for (int t = 0; t < 10 && (exp_a_q.size() > 0 || exp_b_q.size() > 0); t++) @(posedge clk);
    #2;
    if (exp_a_q.size() > 0 || exp_b_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_a_q.size() + exp_b_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
